// File: rtl/aes_inv_cipher.sv
// rtl/aes_inv_cipher.sv - iterative AES-128 inverse cipher, one round per clock
// Optional key cache: define AES_DEC_KEY_CACHE_EN.
module aes_inv_cipher #(
   parameter int NR           = 10,
   parameter bit ZERO_ON_IDLE = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ct_in,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt_out,
   output logic         busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_KEYEXP = 2'd1;
   localparam logic [1:0] ST_ROUND  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   generate
      if (NR != 10) begin : g_nr_check
         $error("aes_inv_cipher: only NR=10 (AES-128) is supported");
      end
   endgenerate

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         y = y >> 1;
         x = xt(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse and maps 0 to 0 as the S-box needs
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r, p;
      r = 8'h01;
      p = gf_mul(a, a);
      for (int i = 0; i < 7; i++) begin
         r = gf_mul(r, p);
         p = gf_mul(p, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] i;
      i = gf_inv(x);
      return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
               ^ {i[3:0], i[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      logic [7:0] b;
      b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // w3^w2 of round key i recovers w3 of round key i-1, which feeds the g() function
   function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot_word(k[63:32] ^ k[31:0]) ^ {rc, 24'h000000};
      w1 = k[95:64] ^ k[127:96];
      w2 = k[63:32] ^ k[95:64];
      w3 = k[31:0]  ^ k[63:32];
      return {w0, w1, w2, w3};
   endfunction

   // Byte n of the state is b[n]; row r, column c lives at n = r + 4c
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s_in);
      logic [0:15][7:0] b, o;
      b = s_in;
      o[0]  = inv_sbox(b[0]);
      o[1]  = inv_sbox(b[13]);
      o[2]  = inv_sbox(b[10]);
      o[3]  = inv_sbox(b[7]);
      o[4]  = inv_sbox(b[4]);
      o[5]  = inv_sbox(b[1]);
      o[6]  = inv_sbox(b[14]);
      o[7]  = inv_sbox(b[11]);
      o[8]  = inv_sbox(b[8]);
      o[9]  = inv_sbox(b[5]);
      o[10] = inv_sbox(b[2]);
      o[11] = inv_sbox(b[15]);
      o[12] = inv_sbox(b[12]);
      o[13] = inv_sbox(b[9]);
      o[14] = inv_sbox(b[6]);
      o[15] = inv_sbox(b[3]);
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [0:3][7:0] a, x2, x4, x8, m9, mb, md, me, o;
      a = col;
      for (int i = 0; i < 4; i++) begin
         x2[i] = xt(a[i]);
         x4[i] = xt(x2[i]);
         x8[i] = xt(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      o[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s_in);
      return {inv_mix_col(s_in[127:96]), inv_mix_col(s_in[95:64]),
              inv_mix_col(s_in[63:32]),  inv_mix_col(s_in[31:0])};
   endfunction

   logic [1:0]   state;
   logic [3:0]   rcnt;
   logic [127:0] s;
   logic [127:0] rk;
   logic [127:0] rk_fwd;
   logic [127:0] rk_inv;
   logic [127:0] t_round;
   logic [127:0] t_mixed;
   logic         accept;

   assign in_ready  = (state == ST_IDLE) && rst_n;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign pt_out    = (ZERO_ON_IDLE && !out_valid) ? 128'h0 : s;

   assign rk_fwd  = fwd_step(rk, rcon(rcnt));
   assign rk_inv  = inv_step(rk, rcon(4'd11 - rcnt));
   assign t_round = inv_shift_sub(s) ^ rk_inv;
   assign t_mixed = inv_mix(t_round);

`ifdef AES_DEC_KEY_CACHE_EN
   logic [127:0] kc_key;
   logic [127:0] kc_k10;
   logic [127:0] key_lat;
   logic         kc_vld;
   logic         kc_hit;

   assign kc_hit = kc_vld && (key_in == kc_key);

   // The cache is written only on the final expansion cycle, so a reset mid-pass never leaves a partial entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kc_key  <= '0;
         kc_k10  <= '0;
         key_lat <= '0;
         kc_vld  <= 1'b0;
      end else begin
         if (accept && !kc_hit) key_lat <= key_in;
         if (state == ST_KEYEXP && rcnt == 4'd10) begin
            kc_key <= key_lat;
            kc_k10 <= rk_fwd;
            kc_vld <= 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         rcnt  <= 4'd0;
         s     <= '0;
         rk    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rcnt <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
                  if (kc_hit) begin
                     s     <= ct_in ^ kc_k10;
                     rk    <= kc_k10;
                     state <= ST_ROUND;
                  end else begin
                     s     <= ct_in;
                     rk    <= key_in;
                     state <= ST_KEYEXP;
                  end
`else
                  s     <= ct_in;
                  rk    <= key_in;
                  state <= ST_KEYEXP;
`endif
               end
            end
            ST_KEYEXP: begin
               rk <= rk_fwd;
               if (rcnt == 4'd10) begin
                  s     <= s ^ rk_fwd;
                  rcnt  <= 4'd1;
                  state <= ST_ROUND;
               end else begin
                  rcnt <= rcnt + 4'd1;
               end
            end
            ST_ROUND: begin
               rk <= rk_inv;
               if (rcnt == 4'd10) begin
                  s     <= t_round;
                  rcnt  <= 4'd0;
                  state <= ST_DONE;
               end else begin
                  s    <= t_mixed;
                  rcnt <= rcnt + 4'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
